rca_result_accum: RTL
=====================

// Module: rca_result_accum
// PURPOSE
//  Downstream consumer of the 4-bit ripple-carry adder: takes its 5-bit result
//  (carry-out as MSB) under a valid/ready handshake and buffers it in a 2-entry
//  skid buffer. Accumulates FRAME_LEN results into one sum, then presents the
//  frame sum with a valid/ready handshake to the next stage.
// PARAMETERS
//  RES_W      5   width of incoming adder result (o_result[4:0])
//  ACC_W      8   accumulator/sum width; lossless when >= RES_W+clog2(FRAME_LEN)
//  FRAME_LEN  8   results per frame, >=2
// PORTS
//  i_clk        in   1      clock, rising edge
//  i_rst_n      in   1      asynchronous active-low reset
//  i_clear      in   1      sync abort: drop frame, flush buffer
//  i_valid      in   1      i_result valid
//  i_result     in   RES_W  adder result, unsigned
//  o_in_ready   out  1      buffer can accept (registered)
//  o_sum_valid  out  1      frame sum valid
//  o_sum        out  ACC_W  frame sum
//  o_ovf        out  1      frame saturated (only with RCA_ACC_SAT_EN)
//  i_out_ready  in   1      downstream accepts o_sum
//  o_busy       out  1      a frame is partly accumulated or held
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, acc=0, count=0,
//    buffer empty, state IDLE. o_in_ready=1 from first edge after release.
//  - Input transfer: i_valid & o_in_ready at a rising edge. o_in_ready = !full.
//    Buffer holds 2 entries, so no sample is lost when ready drops.
//  - The accumulator pops the buffer head when it is non-empty and
//    state!=DONE. On pop, acc <= acc + zero-extended result and count++.
//  - Latency: a sample accepted at edge N enters the buffer. The earliest pop is
//    edge N+1. Final sample accepted at edge N gives o_sum_valid high after N+1.
//  - FSM: IDLE -(pop)-> ACCUM. ACCUM -(pop with count==FRAME_LEN-1)-> DONE,
//    and that edge sets o_sum_valid=1.
//    DONE -(i_out_ready)-> IDLE: o_sum_valid=0, acc=0, count=0.
//    If the buffer is non-empty in that same cycle, the head is popped on the
//    same edge into the fresh frame (acc=sample, count=1, state ACCUM).
//  - o_sum, o_ovf and o_sum_valid stay stable while in DONE with i_out_ready=0.
//    Pops stall; the buffer fills, then o_in_ready=0.
//  - i_clear (priority over all except reset): next edge gives state IDLE,
//    acc/count/o_ovf/o_sum_valid=0, buffer empty. A concurrent input is dropped.
//  - o_busy = (state!=IDLE).
//  - Arithmetic: unsigned. Without the feature, overflow wraps mod 2^ACC_W.
// CONFIGURATION
//  - RCA_ACC_SAT_EN defined: an add whose true sum exceeds 2^ACC_W-1 saturates
//    acc to all-ones and sets o_ovf. o_ovf is sticky until the frame leaves
//    DONE, or until i_clear or reset.
//  - Not defined: wrap-around, o_ovf tied 0.
// STRUCTURE
//  - Package rca_pkg: RES_W/ACC_W defaults, state enum {IDLE,ACCUM,DONE}, and
//    function clog2 for the count width.
//  - Sub-module rca_skid_buf: 2-entry valid/ready buffer, width RES_W, with
//    flush input. Instantiated once. FSM/accumulator in the top.
// TESTING
//  1. 8 x 5'd31, i_out_ready=1 -> one-cycle o_sum_valid, o_sum=8'd248, o_ovf=0.
//  2. 16 results 5'd1 back-to-back, i_out_ready=1 -> two sums of 8. No input
//     stall (o_in_ready stays 1).
//  3. Frame done, i_out_ready=0 for 5 cycles while streaming -> 2 more accepted,
//     then o_in_ready=0. o_sum stays fixed. Release -> next frame picks up
//     buffered samples.
//  4. 3 samples of 5'd7, then i_clear -> o_busy=0. A following 8 x 5'd2 frame
//     gives o_sum=16.
//  5. i_rst_n low mid-frame (asynchronous, between edges) -> all outputs 0 at
//     once. After release, a fresh frame sums correctly.
//  6. ACC_W=6, 8 x 5'd31 -> macro off: o_sum=56, o_ovf=0.
//     Macro on: o_sum=63, o_ovf=1, cleared after handshake.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared defaults, FSM state type and constant helpers for the adder-result
// accumulator.
package rca_pkg;

    localparam int unsigned RES_W_DEF     = 5;
    localparam int unsigned ACC_W_DEF     = 8;
    localparam int unsigned FRAME_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // Bits needed to hold values 0 .. v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rca_result_accum_if.sv
// Handshake bundle between the adder-result producer, the accumulator and the
// frame-sum consumer. master = environment side, slave = rca_result_accum.
interface rca_result_accum_if #(
    parameter int unsigned RES_W = 5,
    parameter int unsigned ACC_W = 8
);
    logic             i_valid;
    logic [RES_W-1:0] i_result;
    logic             o_in_ready;
    logic             o_sum_valid;
    logic [ACC_W-1:0] o_sum;
    logic             o_ovf;
    logic             i_out_ready;

    modport master (
        output i_valid, i_result, i_out_ready,
        input  o_in_ready, o_sum_valid, o_sum, o_ovf
    );

    modport slave (
        input  i_valid, i_result, i_out_ready,
        output o_in_ready, o_sum_valid, o_sum, o_ovf
    );
endinterface

// File: rtl/rca_skid_buf.sv
// Two-entry valid/ready buffer with registered ready and synchronous flush.
// Entry 0 is always the head; a pop shifts entry 1 down.
module rca_skid_buf
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = RES_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic             push;
    logic             pop;

    assign push    = i_valid & o_ready;
    assign pop     = i_ready & (cnt != 2'd0);
    assign o_valid = (cnt != 2'd0);
    assign o_data  = ent0;

    always_comb begin
        cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= 2'd0;
            ent0    <= '0;
            ent1    <= '0;
            o_ready <= 1'b0;
        end else if (i_flush) begin
            cnt     <= 2'd0;
            o_ready <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            o_ready <= (cnt_nxt != 2'd2);
            // ready is low when full, so push and a full pop never coincide
            if (pop) begin
                ent0 <= (cnt == 2'd2) ? ent1 : i_data;
            end else if (push) begin
                if (cnt == 2'd0) ent0 <= i_data;
                else             ent1 <= i_data;
            end
        end
    end
endmodule

// File: rtl/rca_result_accum.sv
// Accumulates FRAME_LEN adder results into one frame sum behind a 2-entry buffer.
// Define RCA_ACC_SAT_EN to saturate on overflow and report it on o_ovf.
module rca_result_accum
    import rca_pkg::*;
#(
    parameter int unsigned RES_W     = RES_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    rca_result_accum_if.slave   bus,
    output logic                o_busy
);
    localparam int unsigned     CNT_W = clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             sum_valid;
    logic             ovf;

    logic             head_valid;
    logic [RES_W-1:0] head;
    logic             pop;
    logic [ACC_W-1:0] sample;
    logic [ACC_W-1:0] acc_add;
    logic             ovf_add;

    rca_skid_buf #(.WIDTH(RES_W)) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_clear),
        .i_valid (bus.i_valid),
        .i_data  (bus.i_result),
        .o_ready (bus.o_in_ready),
        .o_valid (head_valid),
        .o_data  (head),
        .i_ready (pop)
    );

    // In DONE the head may only move when the sum is handed off that same edge.
    assign pop    = !i_clear && head_valid && ((state != DONE) || bus.i_out_ready);
    assign sample = ACC_W'(head);

`ifdef RCA_ACC_SAT_EN
    logic [ACC_W:0] sum_full;
    always_comb begin
        sum_full = {1'b0, acc} + {1'b0, sample};
        acc_add  = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
        ovf_add  = sum_full[ACC_W];
    end
`else
    always_comb begin
        acc_add = acc + sample;
        ovf_add = 1'b0;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sum_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (i_clear) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sum_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (pop) begin
                        acc <= acc_add;
                        ovf <= ovf | ovf_add;
                        if (count == LAST) begin
                            state     <= DONE;
                            sum_valid <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.i_out_ready) begin
                        sum_valid <= 1'b0;
                        ovf       <= 1'b0;
                        if (pop) begin
                            acc   <= sample;
                            count <= CNT_W'(1);
                            state <= ACCUM;
                        end else begin
                            acc   <= '0;
                            count <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_sum_valid = sum_valid;
    assign bus.o_sum       = acc;
    assign bus.o_ovf       = ovf;
    assign o_busy          = (state != IDLE);
endmodule
